// File: rtl/multicycle_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// ctrl_pkg: shared types and constants for the RV32I multi-cycle controller.
//   state_e     - controller FSM states
//   alu_op_e    - ALU operation codes driven on alu_op_o
//   dec_mode_e  - which instruction class the ALU-op decoder interprets
//   OP_*        - RV32I major opcodes (instr[6:0])
//   SRC1_*/SRC2_* - ALU operand select encodings
//   branch_taken  - resolves a branch from funct3 and the ALU zero flag
// ---------------------------------------------------------------------------
package ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_EXEC_R   = 4'd2,
    S_EXEC_I   = 4'd3,
    S_WB_ALU   = 4'd4,
    S_ADDR     = 4'd5,
    S_MEM_RD   = 4'd6,
    S_MEM_WR   = 4'd7,
    S_WB_MEM   = 4'd8,
    S_BRANCH   = 4'd9,
    S_JAL      = 4'd10,
    S_JALR_TGT = 4'd11,
    S_JALR     = 4'd12,
    S_UPPER    = 4'd13,
    S_ILLEGAL  = 4'd14
  } state_e;

  localparam state_e ResetState = S_FETCH;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLL  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9
  } alu_op_e;

  typedef enum logic [1:0] {
    DEC_R  = 2'd0,
    DEC_I  = 2'd1,
    DEC_BR = 2'd2
  } dec_mode_e;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic       SRC1_RS1  = 1'b0;
  localparam logic       SRC1_PC   = 1'b1;
  localparam logic [1:0] SRC2_RS2  = 2'd0;
  localparam logic [1:0] SRC2_IMM  = 2'd1;
  localparam logic [1:0] SRC2_FOUR = 2'd2;

  // EQ/GE/GEU branch on zero, NE/LT/LTU on non-zero; funct3 bits 2 and 0
  // each flip the sense, so the whole table collapses to an XOR.
  function automatic logic branch_taken(input logic [2:0] f3, input logic zero);
    return zero ^ f3[2] ^ f3[0];
  endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// ---------------------------------------------------------------------------
// multicycle_ctrl_if: data-memory request/ready handshake of the controller.
//   mem_r_en_o  - read request, held until mem_ready_i
//   mem_wr_en_o - write request, held until mem_ready_i
//   mem_ready_i - access complete
// master = controller side, slave = memory/arbiter side.
// ---------------------------------------------------------------------------
interface multicycle_ctrl_if;
  logic mem_r_en_o;
  logic mem_wr_en_o;
  logic mem_ready_i;

  modport master (output mem_r_en_o, output mem_wr_en_o, input mem_ready_i);
  modport slave  (input mem_r_en_o, input mem_wr_en_o, output mem_ready_i);
endinterface

// File: rtl/multicycle_ctrl_alu_op_decoder.sv
// ---------------------------------------------------------------------------
// alu_op_decoder: combinational funct3/funct7 -> ALU operation.
//   mode_i    - DEC_R (register ops), DEC_I (immediate ops), DEC_BR (branches)
//   funct3_i  - instr[14:12]
//   funct7_i  - instr[31:25]
//   alu_op_o  - selected ALU operation (ADD when illegal)
//   illegal_o - encoding not defined for this mode
// ---------------------------------------------------------------------------
module alu_op_decoder
  import ctrl_pkg::*;
(
  input  dec_mode_e  mode_i,
  input  logic [2:0] funct3_i,
  input  logic [6:0] funct7_i,
  output alu_op_e    alu_op_o,
  output logic       illegal_o
);

  logic    w_alt;
  logic    w_r_f7_ok;
  alu_op_e w_arith_op;
  alu_op_e w_br_op;
  logic    w_br_bad;

  // funct7[5] selects SUB/SRA; immediates only honour it for shifts
  // because for ADDI it is an immediate bit.
  assign w_alt = funct7_i[5];

  // R-type: funct7 must be all zero, or 0100000 only for SUB and SRA.
  assign w_r_f7_ok = (funct7_i == 7'b0000000) ||
                     ((funct7_i == 7'b0100000) &&
                      ((funct3_i == 3'b000) || (funct3_i == 3'b101)));

  // Arithmetic/logic operation for register and immediate forms.
  always_comb begin
    w_arith_op = ALU_ADD;
    case (funct3_i)
      3'b000:  w_arith_op = (w_alt && (mode_i == DEC_R)) ? ALU_SUB : ALU_ADD;
      3'b001:  w_arith_op = ALU_SLL;
      3'b010:  w_arith_op = ALU_SLT;
      3'b011:  w_arith_op = ALU_SLTU;
      3'b100:  w_arith_op = ALU_XOR;
      3'b101:  w_arith_op = w_alt ? ALU_SRA : ALU_SRL;
      3'b110:  w_arith_op = ALU_OR;
      3'b111:  w_arith_op = ALU_AND;
      default: w_arith_op = ALU_ADD;
    endcase
  end

  // Branch compare operation; funct3 010/011 have no branch meaning.
  always_comb begin
    w_br_op  = ALU_ADD;
    w_br_bad = 1'b0;
    case (funct3_i)
      3'b000, 3'b001: w_br_op = ALU_SUB;
      3'b100, 3'b101: w_br_op = ALU_SLT;
      3'b110, 3'b111: w_br_op = ALU_SLTU;
      default:        w_br_bad = 1'b1;
    endcase
  end

  // Final mux by instruction class.
  always_comb begin
    alu_op_o  = ALU_ADD;
    illegal_o = 1'b0;
    case (mode_i)
      DEC_BR: begin
        alu_op_o  = w_br_op;
        illegal_o = w_br_bad;
      end
      DEC_R: begin
        alu_op_o  = w_r_f7_ok ? w_arith_op : ALU_ADD;
        illegal_o = !w_r_f7_ok;
      end
      default: begin
        alu_op_o  = w_arith_op;
        illegal_o = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// ---------------------------------------------------------------------------
// multicycle_ctrl: RV32I multi-cycle control FSM.
// Sequences fetch/decode/execute/memory/writeback and drives the datapath
// enables and selects. Outputs decode the state register (Moore) except the
// branch PC write, which also depends on zero_i.
//   clk_i, rst_i          - clock, synchronous active-high reset
//   op_code_i/funct3_i/funct7_i - fields of the latched instruction
//   zero_i                - ALU result is zero
//   mem_if (master)       - data-memory request/ready handshake
//   ir_wr_en_o, pc_wr_en_o, pc_src_sel_o, alu_src1_sel_o, alu_src2_sel_o,
//   alu_op_o, regf_wr_en_o, regf_wr_src_sel_o - datapath controls
//   illegal_o             - sticky illegal-instruction flag
// Optional: define PERF_CNT_EN to add cycle_cnt_o / instret_cnt_o (64-bit).
// ---------------------------------------------------------------------------
module multicycle_ctrl
  import ctrl_pkg::*;
(
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [6:0]         op_code_i,
  input  logic [2:0]         funct3_i,
  input  logic [6:0]         funct7_i,
  input  logic               zero_i,
  multicycle_ctrl_if.master  mem_if,
  output logic               ir_wr_en_o,
  output logic               pc_wr_en_o,
  output logic               pc_src_sel_o,
  output logic               alu_src1_sel_o,
  output logic [1:0]         alu_src2_sel_o,
  output logic [3:0]         alu_op_o,
  output logic               regf_wr_en_o,
  output logic               regf_wr_src_sel_o,
  output logic               illegal_o
`ifdef PERF_CNT_EN
  ,
  output logic [63:0]        cycle_cnt_o,
  output logic [63:0]        instret_cnt_o
`endif
);

  state_e    r_state;
  state_e    w_state_nxt;
  dec_mode_e w_dec_mode;
  alu_op_e   w_dec_alu_op;
  logic      w_dec_illegal;
  logic      r_illegal;
  logic      w_mem_r_en;
  logic      w_mem_wr_en;

  assign w_dec_mode = (r_state == S_BRANCH) ? DEC_BR :
                      (r_state == S_EXEC_R) ? DEC_R  : DEC_I;

  alu_op_decoder u_alu_op_decoder (
    .mode_i    (w_dec_mode),
    .funct3_i  (funct3_i),
    .funct7_i  (funct7_i),
    .alu_op_o  (w_dec_alu_op),
    .illegal_o (w_dec_illegal)
  );

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= ResetState;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Sticky illegal flag: set on entry to S_ILLEGAL, cleared only by reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_illegal <= 1'b0;
    end else begin
      r_illegal <= r_illegal | (w_state_nxt == S_ILLEGAL);
    end
  end

  // Next-state and datapath control decode.
  always_comb begin
    w_state_nxt       = r_state;
    ir_wr_en_o        = 1'b0;
    pc_wr_en_o        = 1'b0;
    pc_src_sel_o      = 1'b0;
    alu_src1_sel_o    = SRC1_RS1;
    alu_src2_sel_o    = SRC2_RS2;
    alu_op_o          = ALU_ADD;
    regf_wr_en_o      = 1'b0;
    regf_wr_src_sel_o = 1'b0;
    w_mem_r_en        = 1'b0;
    w_mem_wr_en       = 1'b0;
    case (r_state)
      S_FETCH: begin
        ir_wr_en_o     = 1'b1;
        pc_wr_en_o     = 1'b1;
        alu_src1_sel_o = SRC1_PC;
        alu_src2_sel_o = SRC2_FOUR;
        w_state_nxt    = S_DECODE;
      end
      S_DECODE: begin
        // old PC + imm is captured as the branch/jump target
        alu_src1_sel_o = SRC1_PC;
        alu_src2_sel_o = SRC2_IMM;
        case (op_code_i)
          OP_R:               w_state_nxt = S_EXEC_R;
          OP_I:               w_state_nxt = S_EXEC_I;
          OP_LOAD, OP_STORE:  w_state_nxt = S_ADDR;
          OP_BRANCH:          w_state_nxt = S_BRANCH;
          OP_JAL:             w_state_nxt = S_JAL;
          // target first, so a link write to rd == rs1 cannot corrupt it
          OP_JALR:            w_state_nxt = S_JALR_TGT;
          OP_LUI, OP_AUIPC:   w_state_nxt = S_UPPER;
          default:            w_state_nxt = S_ILLEGAL;
        endcase
      end
      S_EXEC_R: begin
        alu_src2_sel_o = SRC2_RS2;
        alu_op_o       = w_dec_alu_op;
        w_state_nxt    = w_dec_illegal ? S_ILLEGAL : S_WB_ALU;
      end
      S_EXEC_I: begin
        alu_src2_sel_o = SRC2_IMM;
        alu_op_o       = w_dec_alu_op;
        w_state_nxt    = S_WB_ALU;
      end
      S_WB_ALU: begin
        regf_wr_en_o = 1'b1;
        w_state_nxt  = S_FETCH;
      end
      S_ADDR: begin
        alu_src2_sel_o = SRC2_IMM;
        w_state_nxt    = (op_code_i == OP_LOAD) ? S_MEM_RD : S_MEM_WR;
      end
      S_MEM_RD: begin
        w_mem_r_en  = 1'b1;
        w_state_nxt = mem_if.mem_ready_i ? S_WB_MEM : S_MEM_RD;
      end
      S_MEM_WR: begin
        w_mem_wr_en = 1'b1;
        w_state_nxt = mem_if.mem_ready_i ? S_FETCH : S_MEM_WR;
      end
      S_WB_MEM: begin
        regf_wr_en_o      = 1'b1;
        regf_wr_src_sel_o = 1'b1;
        w_state_nxt       = S_FETCH;
      end
      S_BRANCH: begin
        alu_src2_sel_o = SRC2_RS2;
        alu_op_o       = w_dec_alu_op;
        pc_src_sel_o   = 1'b1;
        pc_wr_en_o     = !w_dec_illegal && branch_taken(funct3_i, zero_i);
        w_state_nxt    = w_dec_illegal ? S_ILLEGAL : S_FETCH;
      end
      S_JAL: begin
        alu_src1_sel_o = SRC1_PC;
        alu_src2_sel_o = SRC2_FOUR;
        regf_wr_en_o   = 1'b1;
        pc_src_sel_o   = 1'b1;
        pc_wr_en_o     = 1'b1;
        w_state_nxt    = S_FETCH;
      end
      S_JALR_TGT: begin
        // PC <= rs1 + imm straight from the ALU; datapath clears bit 0
        alu_src2_sel_o = SRC2_IMM;
        pc_wr_en_o     = 1'b1;
        w_state_nxt    = S_JALR;
      end
      S_JALR: begin
        alu_src1_sel_o = SRC1_PC;
        alu_src2_sel_o = SRC2_FOUR;
        regf_wr_en_o   = 1'b1;
        w_state_nxt    = S_FETCH;
      end
      S_UPPER: begin
        // LUI adds imm to operand A read as x0 by the datapath for U-type
        alu_src1_sel_o = (op_code_i == OP_AUIPC) ? SRC1_PC : SRC1_RS1;
        alu_src2_sel_o = SRC2_IMM;
        w_state_nxt    = S_WB_ALU;
      end
      S_ILLEGAL: begin
        w_state_nxt = S_ILLEGAL;
      end
      default: begin
        w_state_nxt = ResetState;
      end
    endcase
  end

  assign mem_if.mem_r_en_o  = w_mem_r_en;
  assign mem_if.mem_wr_en_o = w_mem_wr_en;
  assign illegal_o          = r_illegal;

`ifdef PERF_CNT_EN
  logic [63:0] r_cycle_cnt;
  logic [63:0] r_instret_cnt;

  // Free-running cycle counter and retired-instruction counter; an
  // instruction retires on the step back into S_FETCH.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_cycle_cnt   <= 64'd0;
      r_instret_cnt <= 64'd0;
    end else begin
      r_cycle_cnt <= r_cycle_cnt + 64'd1;
      if ((r_state != S_FETCH) && (w_state_nxt == S_FETCH)) begin
        r_instret_cnt <= r_instret_cnt + 64'd1;
      end else begin
        r_instret_cnt <= r_instret_cnt;
      end
    end
  end

  assign cycle_cnt_o   = r_cycle_cnt;
  assign instret_cnt_o = r_instret_cnt;
`endif

endmodule
